// File: rtl/pipe_clock_ctrl.sv
// pipe_clock_ctrl: derives the slow pipeline clock and stage lock from the PLL clock.
// Supports free-run, pause, debounced single-step and a sticky halt from the pipeline.
module pipe_clock_ctrl #(
    parameter int unsigned DIV_COUNT       = 1000000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LOCK_DELAY      = 16
) (
    input  logic        I_CLOCK,
    input  logic        I_LOCK,
    input  logic        I_RUN_MODE,
    input  logic        I_STEP_KEY_N,
    input  logic        I_HALT,
    output logic        O_CLOCK,
    output logic        O_LOCK,
    output logic [2:0]  O_STATE,
    output logic [15:0] O_CYCLE_COUNT
);

    localparam int unsigned DIV_W = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned LK_W  = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV_COUNT);
    localparam logic [DB_W-1:0]  DB_TC  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LK_W-1:0]  LK_TC  = LK_W'(LOCK_DELAY - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        STEP_HI   = 3'd3,
        STEP_LO   = 3'd4,
        HALTED    = 3'd5
    } state_t;

    logic [1:0] run_sync;
    logic [1:0] key_sync;
    logic [1:0] halt_sync;
    logic       run_s;
    logic       key_s;
    logic       halt_s;

    logic [DB_W-1:0] db_cnt;
    logic            key_db;
    logic            press;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LK_W-1:0]  lk_cnt_q, lk_cnt_d;
    logic             clk_q, clk_d;
    logic             lock_q, lock_d;
    logic [15:0]      cycle_cnt_q, cycle_cnt_d;

    assign run_s  = run_sync[1];
    assign key_s  = key_sync[1];
    assign halt_s = halt_sync[1];

    // Two-flop synchronisers for the asynchronous switch, key and halt inputs
    always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            run_sync  <= '0;
            key_sync  <= '0;
            halt_sync <= '0;
        end else begin
            run_sync  <= {run_sync[0], I_RUN_MODE};
            key_sync  <= {key_sync[0], I_STEP_KEY_N};
            halt_sync <= {halt_sync[0], I_HALT};
        end
    end

    // Key debounce: level accepted after DEBOUNCE_CYCLES consecutive differing samples; press on release->press
    always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            db_cnt <= '0;
            key_db <= 1'b1;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s != key_db) begin
                if (db_cnt == DB_TC) begin
                    db_cnt <= '0;
                    key_db <= key_s;
                    press  <= key_db & ~key_s;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // State, divider, output clock, lock and rise counter registers
    always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            state_q     <= WAIT_LOCK;
            div_q       <= '0;
            lk_cnt_q    <= '0;
            clk_q       <= 1'b0;
            lock_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            lk_cnt_q    <= lk_cnt_d;
            clk_q       <= clk_d;
            lock_q      <= lock_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // Next-state logic; RUN only reconsiders mode at the falling toggle so high phases are never cut short
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        lk_cnt_d    = lk_cnt_q;
        clk_d       = clk_q;
        lock_d      = lock_q;
        cycle_cnt_d = cycle_cnt_q;

        case (state_q)
            WAIT_LOCK: begin
                clk_d = 1'b0;
                div_d = '0;
                if (lk_cnt_q == LK_TC) begin
                    lock_d  = 1'b1;
                    state_d = run_s ? RUN : PAUSE;
                end else begin
                    lk_cnt_d = lk_cnt_q + LK_W'(1);
                end
            end
            RUN: begin
                if (div_q == DIV_TC) begin
                    div_d = '0;
                    clk_d = ~clk_q;
                    if (clk_q) begin
                        if (halt_s) begin
                            state_d = HALTED;
                        end else if (!run_s) begin
                            state_d = PAUSE;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            PAUSE: begin
                clk_d = 1'b0;
                div_d = '0;
                if (halt_s) begin
                    state_d = HALTED;
                end else if (run_s) begin
                    state_d = RUN;
                end else if (press) begin
                    state_d = STEP_HI;
                    clk_d   = 1'b1;
                end
            end
            STEP_HI: begin
                if (div_q == DIV_TC) begin
                    div_d   = '0;
                    clk_d   = 1'b0;
                    state_d = STEP_LO;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            STEP_LO: begin
                clk_d = 1'b0;
                if (div_q == DIV_TC) begin
                    div_d   = '0;
                    state_d = PAUSE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HALTED: begin
                clk_d = 1'b0;
                div_d = '0;
            end
            default: begin
                state_d = WAIT_LOCK;
                clk_d   = 1'b0;
                div_d   = '0;
            end
        endcase

        if (clk_d && !clk_q) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
    end

    assign O_CLOCK       = clk_q;
    assign O_LOCK        = lock_q;
    assign O_STATE       = state_q;
    assign O_CYCLE_COUNT = cycle_cnt_q;

endmodule
